// File: rtl/mem_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and defaults for the unified memory arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package mem_arb_pkg;

  // Arbiter FSM states; explicit width keeps the encoding stable across tools.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_F = 3'd1,
    BUSY_D = 3'd2,
    RESP_F = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

  // Identity of the requester that owns the current memory transaction.
  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_t;

  localparam int unsigned c_def_starve_limit = 4;
  localparam int unsigned c_def_timeout      = 16;

  // Data normally wins; fetch wins when it is alone or has been starved too long.
  function automatic req_id_t pick_winner(input logic fetch_pending,
                                          input logic data_pending,
                                          input logic fetch_starved);
    if (fetch_pending && (!data_pending || fetch_starved)) begin
      return FETCH;
    end
    return DATA;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : unified_mem_arbiter
// Brief    : Shares one single-ported memory between instruction fetch and
//            load/store, with fetch anti-starvation and a response watchdog.
// Revision : 1.0 - initial release
//==============================================================================
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = c_def_starve_limit,
  parameter int unsigned TIMEOUT      = c_def_timeout
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch side
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  // data side
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ready,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_err,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter widths: starvation counter must hold STARVE_LIMIT, watchdog TIMEOUT-1.
  localparam int unsigned c_sc_w = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned c_wd_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [c_sc_w-1:0] c_starve_max = c_sc_w'(STARVE_LIMIT);
  localparam logic [c_wd_w-1:0] c_wd_last    = c_wd_w'(TIMEOUT - 1);

  arb_state_t        r_state;
  logic [c_sc_w-1:0] r_starve_cnt;
  logic [c_wd_w-1:0] r_wd_cnt;

  logic              w_any_req;
  logic              w_fetch_starved;
  req_id_t           w_grant_id;

  assign w_any_req       = fetch_req | data_req;
  assign w_fetch_starved = (r_starve_cnt == c_starve_max);
  assign w_grant_id      = pick_winner(fetch_req, data_req, w_fetch_starved);

  // FSM, counters and every output register advance together in one block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_wd_cnt     <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      fetch_ready  <= 1'b0;
      fetch_err    <= 1'b0;
      fetch_data   <= '0;
      data_ready   <= 1'b0;
      data_err     <= 1'b0;
      data_rdata   <= '0;
    end else begin
      // Response flags are single-cycle pulses raised only on entry to RESP_x.
      fetch_ready <= 1'b0;
      fetch_err   <= 1'b0;
      data_ready  <= 1'b0;
      data_err    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            mem_req  <= 1'b1;
            r_wd_cnt <= '0;
            if (w_grant_id == FETCH) begin
              mem_we       <= 1'b0;
              mem_addr     <= fetch_addr;
              mem_wdata    <= '0;
              r_starve_cnt <= '0;
              r_state      <= BUSY_F;
            end else begin
              mem_we    <= data_we;
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
              // Only data grants that bypass a waiting fetch count toward starvation.
              if (fetch_req) begin
                if (r_starve_cnt != c_starve_max) begin
                  r_starve_cnt <= r_starve_cnt + 1'b1;
                end
              end else begin
                r_starve_cnt <= '0;
              end
              r_state <= BUSY_D;
            end
          end
        end

        BUSY_F, BUSY_D: begin
          // An ack on the watchdog's last cycle still completes normally.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (r_state == BUSY_F) begin
              fetch_data  <= mem_rdata;
              fetch_ready <= 1'b1;
              r_state     <= RESP_F;
            end else begin
              data_rdata <= mem_we ? '0 : mem_rdata;
              data_ready <= 1'b1;
              r_state    <= RESP_D;
            end
          end else if (r_wd_cnt == c_wd_last) begin
            mem_req <= 1'b0;
            if (r_state == BUSY_F) begin
              fetch_data  <= '0;
              fetch_ready <= 1'b1;
              fetch_err   <= 1'b1;
              r_state     <= RESP_F;
            end else begin
              data_rdata <= '0;
              data_ready <= 1'b1;
              data_err   <= 1'b1;
              r_state    <= RESP_D;
            end
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end

        RESP_F, RESP_D: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_unified_mem_arbiter
// Brief    : Self-checking bench: transaction-level timing model plus directed
//            scenarios with literal expectations.
// Revision : 1.0 - initial release
//==============================================================================
module tb_unified_mem_arbiter;

  localparam int SL = 4;
  localparam int TO = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic        fetch_req  = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready, fetch_err;
  logic [31:0] fetch_data;
  logic        data_req   = 1'b0;
  logic        data_we    = 1'b0;
  logic [31:0] data_addr  = '0;
  logic [31:0] data_wdata = '0;
  logic        data_ready, data_err;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = '0;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_err(fetch_err),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ready(data_ready), .data_rdata(data_rdata),
    .data_err(data_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory behaviour knobs shared by responder and model
  int mem_wait  = 0;
  bit mem_mute  = 1'b0;
  bit force_ack = 1'b0;

  logic [31:0] mem_arr [256];

  // Memory responder: acks after mem_wait cycles of a continuous request.
  initial begin : responder
    bit prev_req;
    int cnt;
    logic [7:0] idx;
    prev_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[64]  = 32'h00500093;
    mem_arr[128] = 32'h12345678;
    mem_arr[192] = 32'hCAFEF00D;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'hA5A5A5A5;
      if (!rst_n) begin
        prev_req = 1'b0;
        cnt = 0;
      end else begin
        if (mem_req) cnt = prev_req ? cnt + 1 : 0;
        prev_req = mem_req;
        idx = mem_addr[9:2];
        if (force_ack || (mem_req && !mem_mute && cnt == mem_wait)) begin
          mem_ack = 1'b1;
          if (mem_req && mem_we) mem_arr[idx] = mem_wdata;
          else mem_rdata = mem_arr[idx];
        end
      end
    end
  end

  // Transaction-level model: each grant opens a mem_req window whose length
  // follows from the memory wait or the watchdog, then one ready cycle.
  int cyc = 0;
  int idle_at = 0, win_lo = -1, win_hi = -2, rdy_at = -1, starve = 0;
  bit own_f = 1'b0, p_err = 1'b0, m_we = 1'b0;
  logic [31:0] p_data = '0, m_addr = '0, m_wdata = '0;
  logic [31:0] mdl_mem [256];
  logic        exp_mem_req = 0, exp_mem_we = 0, exp_store = 0;
  logic [31:0] exp_mem_addr = '0, exp_mem_wdata = '0;
  logic        exp_f_ready = 0, exp_f_err = 0, exp_d_ready = 0, exp_d_err = 0;
  logic [31:0] exp_f_data = '0, exp_d_rdata = '0;

  initial begin : model
    int k, lat;
    bit gf, ok;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 32'h0;
    mdl_mem[64]  = 32'h00500093;
    mdl_mem[128] = 32'h12345678;
    mdl_mem[192] = 32'hCAFEF00D;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        idle_at = 0; win_lo = -1; win_hi = -2; rdy_at = -1; starve = 0;
        exp_mem_req = 0; exp_mem_we = 0; exp_store = 0;
        exp_mem_addr = '0; exp_mem_wdata = '0;
        exp_f_ready = 0; exp_f_err = 0; exp_d_ready = 0; exp_d_err = 0;
        exp_f_data = '0; exp_d_rdata = '0;
      end else begin
        k = cyc;
        if (k >= idle_at) begin
          if (fetch_req || data_req) begin
            gf = fetch_req && (!data_req || starve == SL);
            if (gf) starve = 0;
            else if (fetch_req) starve = (starve < SL) ? starve + 1 : SL;
            else starve = 0;
            ok  = !mem_mute && (mem_wait <= TO - 1);
            lat = ok ? mem_wait : TO - 1;
            win_lo = k + 1; win_hi = k + 1 + lat;
            rdy_at = k + 2 + lat; idle_at = k + 3 + lat;
            own_f = gf; p_err = !ok;
            m_addr  = gf ? fetch_addr : data_addr;
            m_we    = gf ? 1'b0 : data_we;
            m_wdata = data_wdata;
            if (!ok) p_data = '0;
            else if (m_we) begin
              p_data = '0;
              mdl_mem[m_addr[9:2]] = m_wdata;
            end else p_data = mdl_mem[m_addr[9:2]];
          end else begin
            idle_at = k + 1;
          end
        end
        k = k + 1;
        exp_mem_req   = (k >= win_lo) && (k <= win_hi);
        exp_mem_addr  = m_addr;
        exp_mem_we    = m_we;
        exp_mem_wdata = m_wdata;
        exp_store     = m_we;
        exp_f_ready   = (k == rdy_at) && own_f;
        exp_f_err     = exp_f_ready && p_err;
        exp_d_ready   = (k == rdy_at) && !own_f;
        exp_d_err     = exp_d_ready && p_err;
        if (exp_f_ready) exp_f_data  = p_data;
        if (exp_d_ready) exp_d_rdata = p_data;
        cyc = k;
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic cmp_cycle();
    chk("mem_req", mem_req, exp_mem_req);
    if (exp_mem_req) begin
      chk("mem_we", mem_we, exp_mem_we);
      chk("mem_addr", mem_addr, exp_mem_addr);
      if (exp_store) chk("mem_wdata", mem_wdata, exp_mem_wdata);
    end
    chk("fetch_ready", fetch_ready, exp_f_ready);
    chk("fetch_err", fetch_err, exp_f_err);
    chk("data_ready", data_ready, exp_d_ready);
    chk("data_err", data_err, exp_d_err);
    chk("fetch_data", fetch_data, exp_f_data);
    chk("data_rdata", data_rdata, exp_d_rdata);
  endtask

  task automatic step();
    @(negedge clk);
    cmp_cycle();
  endtask

  // Issue one request from an idle cycle and check it against literals.
  task automatic txn(input string nm, input bit is_f, input bit we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_data,
                     input bit exp_err, input int exp_reqcyc);
    int t0, nreq;
    bit seen;
    t0 = cyc; nreq = 0; seen = 1'b0;
    if (is_f) begin
      fetch_req = 1'b1; fetch_addr = addr;
    end else begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (i == 0) begin
        chk({nm, " mem_req first cycle"}, mem_req, 1);
        chk({nm, " mem_we first cycle"}, mem_we, we & !is_f);
      end
      nreq += int'(mem_req);
      if (is_f ? fetch_ready : data_ready) begin
        seen = 1'b1;
        chk({nm, " latency"}, cyc - t0, exp_lat);
        chk({nm, " data"}, is_f ? fetch_data : data_rdata, exp_data);
        chk({nm, " err"}, is_f ? fetch_err : data_err, exp_err);
        chk({nm, " mem_req cycles"}, nreq, exp_reqcyc);
        fetch_req = 1'b0;
        data_req  = 1'b0;
      end
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: no ready within 40 cycles", nm);
      fetch_req = 1'b0;
      data_req  = 1'b0;
    end
    step();
  endtask

  initial begin : stim
    logic [9:0] order;
    int ng;
    bit prev, done;

    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    txn("fetch", 1'b1, 1'b0, 32'h100, 32'h0, 2, 32'h00500093, 1'b0, 1);

    mem_wait = 2;
    txn("store", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4, 32'h0, 1'b0, 3);
    txn("load", 1'b0, 1'b0, 32'h40, 32'h0, 4, 32'hDEADBEEF, 1'b0, 3);

    // both requesters held continuously
    mem_wait = 0;
    order = '0; ng = 0; prev = 1'b0; done = 1'b0;
    fetch_addr = 32'h200; data_addr = 32'h300; data_we = 1'b0;
    fetch_req = 1'b1; data_req = 1'b1;
    for (int i = 0; i < 80 && !done; i++) begin
      step();
      if (mem_req && !prev) begin
        if (ng < 10) order[ng] = (mem_addr == 32'h200);
        ng++;
      end
      prev = mem_req;
      if (ng >= 10 && fetch_ready) done = 1'b1;
    end
    fetch_req = 1'b0; data_req = 1'b0;
    chk("grant sequence complete", done, 1);
    chk("grant order (bit=fetch)", order, 10'h210);
    step();

    mem_mute = 1'b1;
    txn("timeout", 1'b1, 1'b0, 32'h104, 32'h0, TO + 1, 32'h0, 1'b1, TO);
    mem_mute = 1'b0;

    // stray ack while idle must be ignored
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("late ack fetch_ready", fetch_ready, 0);
      chk("late ack data_ready", data_ready, 0);
    end

    mem_wait = TO - 1;
    txn("ack at expiry", 1'b0, 1'b0, 32'h40, 32'h0, TO + 1, 32'hDEADBEEF, 1'b0, TO);

    // reset in the middle of a data transaction
    mem_mute = 1'b1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300;
    step(); step(); step();
    #7;
    rst_n = 1'b0;
    data_req = 1'b0;
    #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset data_rdata", data_rdata, 0);
    chk("reset data_ready", data_ready, 0);
    step();
    step();
    chk("reset no data_ready", data_ready, 0);
    rst_n = 1'b1;
    mem_mute = 1'b0;
    mem_wait = 0;
    step();
    txn("post-reset fetch", 1'b1, 1'b0, 32'h100, 32'h0, 2, 32'h00500093, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
